// File: rtl/lcd_nibble_writer_pkg.sv
// Shared definitions for the character-LCD nibble writer: default HD44780
// timing (in 50 MHz clock cycles) and the latched request record.
package lcd_nibble_writer_pkg;

  localparam int LCD_SETUP_CYC  = 2;
  localparam int LCD_E_HIGH_CYC = 12;
  localparam int LCD_HOLD_CYC   = 1;
  localparam int LCD_GAP_CYC    = 50;
  localparam int LCD_WAIT_CYC   = 2000;
  localparam int LCD_CNT_W      = 16;

  // One accepted request, captured on the accept edge and held for the transfer.
  typedef struct packed {
    logic [7:0] data;
    logic       rs;
    logic       nib_only;
  } lcd_req_t;

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives the Spartan-3E 4-bit HD44780 bus (SF_D[11:8], E, RS, RW) for one
// command/character byte per request. A single down-counter times each phase;
// every bus output comes straight from a flop so nothing ripples from inputs.
module lcd_nibble_writer
  import lcd_nibble_writer_pkg::*;
#(
  parameter int SETUP_CYC      = LCD_SETUP_CYC,
  parameter int E_HIGH_CYC     = LCD_E_HIGH_CYC,
  parameter int HOLD_CYC       = LCD_HOLD_CYC,
  parameter int NIBBLE_GAP_CYC = LCD_GAP_CYC,
  parameter int BYTE_WAIT_CYC  = LCD_WAIT_CYC,
  parameter int CNT_W          = LCD_CNT_W
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iNibbleOnly,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SETUP_H = 4'd1;
  localparam logic [3:0] S_PULSE_H = 4'd2;
  localparam logic [3:0] S_HOLD_H  = 4'd3;
  localparam logic [3:0] S_GAP     = 4'd4;
  localparam logic [3:0] S_SETUP_L = 4'd5;
  localparam logic [3:0] S_PULSE_L = 4'd6;
  localparam logic [3:0] S_HOLD_L  = 4'd7;
  localparam logic [3:0] S_WAIT    = 4'd8;

  // Counter reload values: a phase of N cycles loads N-1 and leaves at zero.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_E     = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(BYTE_WAIT_CYC - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lcd_req_t         req_q, req_d;

  logic             e_d;
  logic             rs_d;
  logic             done_d;
  logic             low_phase;
  logic [3:0]       data_d;

  // RW is tied low: this writer never reads the busy flag back.
  assign oLCD_RW = 1'b0;

  // Next state, phase counter and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    if (state_q == S_IDLE) begin
      if (iValid) begin
        req_d   = '{data: iData, rs: iRS, nib_only: iNibbleOnly};
        state_d = S_SETUP_H;
        cnt_d   = LD_SETUP;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      case (state_q)
        S_SETUP_H: begin state_d = S_PULSE_H; cnt_d = LD_E;     end
        S_PULSE_H: begin state_d = S_HOLD_H;  cnt_d = LD_HOLD;  end
        S_HOLD_H: begin
          if (req_q.nib_only) begin
            state_d = S_WAIT;
            cnt_d   = LD_WAIT;
          end else begin
            state_d = S_GAP;
            cnt_d   = LD_GAP;
          end
        end
        S_GAP:     begin state_d = S_SETUP_L; cnt_d = LD_SETUP; end
        S_SETUP_L: begin state_d = S_PULSE_L; cnt_d = LD_E;     end
        S_PULSE_L: begin state_d = S_HOLD_L;  cnt_d = LD_HOLD;  end
        S_HOLD_L:  begin state_d = S_WAIT;    cnt_d = LD_WAIT;  end
        default:   begin state_d = S_IDLE;    cnt_d = '0;       end
      endcase
    end
  end

  // Bus values for the coming cycle, derived from the next state so they register cleanly.
  always_comb begin
    e_d       = (state_d == S_PULSE_H) || (state_d == S_PULSE_L);
    low_phase = (state_d == S_SETUP_L) || (state_d == S_PULSE_L) ||
                (state_d == S_HOLD_L)  || ((state_d == S_WAIT) && !req_d.nib_only);
    if (state_d == S_IDLE) begin
      data_d = 4'h0;
      rs_d   = 1'b0;
    end else begin
      data_d = low_phase ? req_d.data[3:0] : req_d.data[7:4];
      rs_d   = req_d.rs;
    end
    done_d = (state_q == S_WAIT) && (cnt_q == '0);
  end

  // Control and output registers; reset aborts any transfer in progress.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      oReady    <= 1'b1;
      oDone     <= 1'b0;
      oLCD_E    <= 1'b0;
      oLCD_RS   <= 1'b0;
      oLCD_Data <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      oReady    <= (state_d == S_IDLE);
      oDone     <= done_d;
      oLCD_E    <= e_d;
      oLCD_RS   <= rs_d;
      oLCD_Data <= data_d;
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer: a default-timing instance driven from a vector
// table with a scoreboard, plus an all-ones-timing instance traced cycle by cycle.
module tb_lcd_nibble_writer;

  localparam int SETUP = 2;
  localparam int EHI   = 12;
  localparam int HOLD  = 1;
  localparam int GAP   = 50;
  localparam int BWAIT = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       d_valid, d_rs, d_nib;
  logic [7:0] d_data;
  logic       d_ready, d_done, d_e, d_rs_o, d_rw;
  logic [3:0] d_lcd;
  logic       f_valid, f_rs, f_nib;
  logic [7:0] f_data;
  logic       f_ready, f_done, f_e, f_rs_o, f_rw;
  logic [3:0] f_lcd;

  lcd_nibble_writer #(
    .SETUP_CYC(SETUP), .E_HIGH_CYC(EHI), .HOLD_CYC(HOLD),
    .NIBBLE_GAP_CYC(GAP), .BYTE_WAIT_CYC(BWAIT), .CNT_W(16)
  ) dut_d (
    .Clock(clk), .Reset(rst_n), .iValid(d_valid), .iData(d_data), .iRS(d_rs),
    .iNibbleOnly(d_nib), .oReady(d_ready), .oDone(d_done), .oLCD_E(d_e),
    .oLCD_RS(d_rs_o), .oLCD_RW(d_rw), .oLCD_Data(d_lcd)
  );

  lcd_nibble_writer #(
    .SETUP_CYC(1), .E_HIGH_CYC(1), .HOLD_CYC(1),
    .NIBBLE_GAP_CYC(1), .BYTE_WAIT_CYC(1), .CNT_W(16)
  ) dut_f (
    .Clock(clk), .Reset(rst_n), .iValid(f_valid), .iData(f_data), .iRS(f_rs),
    .iNibbleOnly(f_nib), .oReady(f_ready), .oDone(f_done), .oLCD_E(f_e),
    .oLCD_RS(f_rs_o), .oLCD_RW(f_rw), .oLCD_Data(f_lcd)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0] hi;
    logic [3:0] lo;
    logic       rs;
    logic       nib;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];

  // Transfer monitor for the default instance: E pulses, nibbles, latency.
  logic       e_prev = 1'b0;
  int         e_len = 0;
  int         nib_n = 0;
  int         rise0 = 0, rise1 = 0;
  logic [3:0] nib0 = 4'h0, nib1 = 4'h0;
  exp_t       mex;

  always @(negedge clk) begin
    if (!rst_n) begin
      nib_n  = 0;
      e_len  = 0;
      e_prev = 1'b0;
    end else begin
      if (d_e && !e_prev) begin
        if (nib_n == 0) begin nib0 = d_lcd; rise0 = cyc; end
        if (nib_n == 1) begin nib1 = d_lcd; rise1 = cyc; end
        nib_n++;
        if (sb.size() > 0) check("rs_at_e_rise", d_rs_o, sb[0].rs);
      end
      if (d_e) e_len++;
      if (!d_e && e_prev) begin
        check("e_width", e_len, EHI);
        e_len = 0;
      end
      if (d_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mex = sb.pop_front();
          check("latency", cyc - mex.acc, mex.lat);
          check("first_e_rise", rise0 - mex.acc, SETUP);
          check("pulse_count", nib_n, mex.nib ? 1 : 2);
          check("nibble_hi", nib0, mex.hi);
          if (!mex.nib) begin
            check("nibble_lo", nib1, mex.lo);
            check("e_rise_spacing", rise1 - rise0, SETUP + EHI + HOLD + GAP);
          end
          check("ready_with_done", d_ready, 1);
        end
        nib_n = 0;
      end
      e_prev = d_e;
    end
  end

  // Bus invariants: RW low, data/RS stable across E high and hold, single-cycle done.
  logic       a_eprev = 1'b0, a_rstprev = 1'b0, a_doneprev = 1'b0;
  logic [3:0] a_lcdprev = 4'h0;
  logic       a_rsprev = 1'b0;
  int         hold_left = 0;

  always @(negedge clk) begin
    check("rw_low_d", d_rw, 0);
    check("rw_low_f", f_rw, 0);
    if (rst_n && a_rstprev) begin
      if (a_eprev || hold_left > 0) begin
        check("data_stable", d_lcd, a_lcdprev);
        check("rs_stable", d_rs_o, a_rsprev);
      end
      if (d_done && a_doneprev) check("done_single_cycle", 1, 0);
    end
    if (!d_e && a_eprev) hold_left = HOLD - 1;
    else if (hold_left > 0) hold_left--;
    a_eprev    = d_e;
    a_rstprev  = rst_n;
    a_doneprev = d_done;
    a_lcdprev  = d_lcd;
    a_rsprev   = d_rs_o;
  end

  // Called at a negedge: hold the request until accepted, queue its expectation.
  task automatic send(input logic [7:0] data, input logic rs, input logic nib,
                      input logic [3:0] hi, input logic [3:0] lo, input int lat);
    exp_t ex;
    bit   ok;
    ok = 0;
    d_data = data; d_rs = rs; d_nib = nib; d_valid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (d_ready) begin
        ex.hi = hi; ex.lo = lo; ex.rs = rs; ex.nib = nib; ex.lat = lat;
        ex.acc = cyc + 1;
        sb.push_back(ex);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      if (sb.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic       nib;
    logic [3:0] hi;
    logic [3:0] lo;
    int         lat;
  } vec_t;

  typedef struct {
    logic       e;
    logic [3:0] dat;
    logic       rs;
    logic       done;
    logic       rdy;
  } tr_t;

  vec_t vt[4];
  tr_t  tr[9];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h48, 1'b1, 1'b0, 4'h4, 4'h8, 2080};
    vt[1] = '{8'h30, 1'b0, 1'b1, 4'h3, 4'h0, 2015};
    vt[2] = '{8'hA5, 1'b0, 1'b0, 4'hA, 4'h5, 2080};
    vt[3] = '{8'h0F, 1'b1, 1'b1, 4'h0, 4'h0, 2015};

    tr[0] = '{1'b0, 4'hA, 1'b1, 1'b0, 1'b0};
    tr[1] = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b0};
    tr[2] = '{1'b0, 4'hA, 1'b1, 1'b0, 1'b0};
    tr[3] = '{1'b0, 4'hA, 1'b1, 1'b0, 1'b0};
    tr[4] = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b0};
    tr[5] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0};
    tr[6] = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b0};
    tr[7] = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b0};
    tr[8] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    d_valid = 1'b0; d_data = 8'h00; d_rs = 1'b0; d_nib = 1'b0;
    f_valid = 1'b0; f_data = 8'h00; f_rs = 1'b0; f_nib = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", d_ready, 1);
    check("reset_done", d_done, 0);
    check("reset_e", d_e, 0);
    check("reset_data", d_lcd, 0);
    check("reset_rs", d_rs_o, 0);
    check("reset_ready_f", f_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven transfers on the default-timing instance.
    for (int v = 0; v < 4; v++) begin
      send(vt[v].data, vt[v].rs, vt[v].nib, vt[v].hi, vt[v].lo, vt[v].lat);
      wait_drain();
    end

    // Valid held high with changing inputs; second byte taken on the done cycle.
    d_data = 8'h5A; d_rs = 1'b0; d_nib = 1'b0; d_valid = 1'b1;
    begin
      exp_t ex;
      bit   ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
        if (d_ready) begin
          ex.hi = 4'h5; ex.lo = 4'hA; ex.rs = 1'b0; ex.nib = 1'b0; ex.lat = 2080;
          ex.acc = cyc + 1;
          sb.push_back(ex);
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) check("b2b_first_accept_timeout", 0, 1);
      @(negedge clk);
      check("b2b_busy_after_accept", d_ready, 0);
      d_data = 8'hFF; d_rs = 1'b1; d_nib = 1'b1;
      repeat (40) @(negedge clk);
      d_data = 8'hC3;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
        if (d_ready) begin
          check("b2b_accept_on_done", d_done, 1);
          ex.hi = 4'hC; ex.lo = 4'h3; ex.rs = 1'b1; ex.nib = 1'b1; ex.lat = 2015;
          ex.acc = cyc + 1;
          sb.push_back(ex);
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) check("b2b_second_accept_timeout", 0, 1);
      @(negedge clk);
      d_valid = 1'b0;
      check("b2b_second_busy", d_ready, 0);
    end
    wait_drain();

    // Reset asserted in the middle of the high-nibble E pulse.
    d_data = 8'h48; d_rs = 1'b1; d_nib = 1'b0; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (d_e) begin ok = 1; break; end
        @(negedge clk);
      end
      if (!ok) check("abort_e_timeout", 0, 1);
    end
    repeat (4) @(negedge clk);
    check("abort_pre_e", d_e, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_e", d_e, 0);
    check("abort_data", d_lcd, 0);
    check("abort_rs", d_rs_o, 0);
    check("abort_ready", d_ready, 1);
    check("abort_done", d_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h3C, 1'b0, 1'b0, 4'h3, 4'hC, 2080);
    wait_drain();

    // Exact cycle trace on the all-ones-timing instance.
    f_data = 8'hA5; f_rs = 1'b1; f_nib = 1'b0; f_valid = 1'b1;
    check("trace_ready_before", f_ready, 1);
    @(negedge clk);
    f_valid = 1'b0;
    f_data = 8'h00; f_rs = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("trace_e_%0d", k), f_e, tr[k].e);
      check($sformatf("trace_data_%0d", k), f_lcd, tr[k].dat);
      check($sformatf("trace_rs_%0d", k), f_rs_o, tr[k].rs);
      check($sformatf("trace_done_%0d", k), f_done, tr[k].done);
      check($sformatf("trace_ready_%0d", k), f_ready, tr[k].rdy);
      @(negedge clk);
    end
    check("trace_done_cleared", f_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
